// File: rtl/video_pkg.sv
// Shared pixel types, test-pattern encodings and colour constants for the
// video pipeline blocks.
package video_pkg;

  localparam int PIX_W = 18;
  localparam int CH_W  = 6;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    PAT_FB    = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_BOX   = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_t;

  // Pixels are packed {R,G,B}, each channel either full scale or off.
  localparam pixel_t BLACK   = 18'h00000;
  localparam pixel_t WHITE   = 18'h3FFFF;
  localparam pixel_t YELLOW  = 18'h3FFC0;
  localparam pixel_t CYAN    = 18'h00FFF;
  localparam pixel_t GREEN   = 18'h00FC0;
  localparam pixel_t MAGENTA = 18'h3F03F;
  localparam pixel_t RED     = 18'h3F000;
  localparam pixel_t BLUE    = 18'h0003F;

  function automatic pixel_t barColour(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line; every stage clears to zero on reset.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= dataIn;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dataOut = stage[DEPTH-1];

endmodule

// File: rtl/pixel_stream_source.sv
// Raster scanner producing one pixel per clock from the frame buffer or a
// built-in test pattern, with coordinates delayed to match memory latency.
module pixel_stream_source
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int H_TOTAL     = 1344,
  parameter int V_ACTIVE    = 768,
  parameter int V_TOTAL     = 806,
  parameter int MEM_LATENCY = 2,
  parameter int BOX         = 16,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  input  logic [10:0]       box_x,
  input  logic [9:0]        box_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [17:0]       mem_data,
  output logic [17:0]       pixel,
  output logic [10:0]       x,
  output logic [9:0]        y,
  output logic              active,
  output logic              frame_start
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam int          BAR_W  = H_ACTIVE / 8;
  localparam int          DW     = 1 + 11 + 10 + 1 + 1 + PIX_W;

  state_t      state, nextState;
  logic [10:0] hc, nextHc;
  logic [9:0]  vc, nextVc;
  pattern_t    patSel, nextPat;
  logic [10:0] boxX;
  logic [9:0]  boxY;
  logic        frameStartNext, memRdNext;

  // Reads are decided from the next-state counters so that mem_rd and
  // mem_addr line up with the hc/vc they belong to.
  always_comb begin
    nextState = state;
    nextHc    = hc;
    nextVc    = vc;
    if (state == IDLE) begin
      if (enable) begin
        nextState = SCAN;
        nextHc    = '0;
        nextVc    = '0;
      end
    end else if (hc == H_LAST) begin
      nextHc = '0;
      if (vc == V_LAST) begin
        nextVc = '0;
        if (!enable) begin
          nextState = IDLE;
          nextHc    = H_LAST;
          nextVc    = V_LAST;
        end
      end else begin
        nextVc = vc + 10'd1;
      end
    end else begin
      nextHc = hc + 11'd1;
    end
    frameStartNext = (nextState == SCAN) && (nextHc == '0) && (nextVc == '0);
    nextPat        = frameStartNext ? pattern_t'(pattern_sel) : patSel;
    memRdNext      = (nextState == SCAN) && (nextPat == PAT_FB) &&
                     (nextHc < 11'(H_ACTIVE)) && (nextVc < 10'(V_ACTIVE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hc       <= H_LAST;
      vc       <= V_LAST;
      patSel   <= PAT_FB;
      boxX     <= '0;
      boxY     <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state  <= nextState;
      hc     <= nextHc;
      vc     <= nextVc;
      mem_rd <= memRdNext;
      if (frameStartNext) begin
        patSel   <= pattern_t'(pattern_sel);
        boxX     <= box_x;
        boxY     <= box_y;
        mem_addr <= '0;
      end else if (mem_rd) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  logic        scanning, actNow, inBox;
  logic [2:0]  barIdx;
  logic [11:0] boxRight;
  logic [10:0] boxBottom;
  pixel_t      patPix;

  // Box edges are widened by one bit so a box near the counter limit clips
  // instead of wrapping back to column/row zero.
  always_comb begin
    scanning  = (state == SCAN);
    actNow    = scanning && (hc < 11'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));
    barIdx    = 3'(hc / 11'(BAR_W));
    boxRight  = {1'b0, boxX} + 12'(BOX);
    boxBottom = {1'b0, boxY} + 11'(BOX);
    inBox     = (hc >= boxX) && ({1'b0, hc} < boxRight) &&
                (vc >= boxY) && ({1'b0, vc} < boxBottom);
    patPix    = BLACK;
    if (actNow) begin
      case (patSel)
        PAT_BARS: patPix = barColour(barIdx);
        PAT_BOX:  patPix = inBox ? RED : BLACK;
        default:  patPix = BLACK;
      endcase
    end
  end

  logic [DW-1:0] pipeIn, pipeOut;
  logic          dScan, dAct, dFb;
  logic [10:0]   dHc;
  logic [9:0]    dVc;
  pixel_t        dPix;

  assign pipeIn = scanning ? {1'b1, hc, vc, actNow, (patSel == PAT_FB), patPix}
                           : {1'b0, H_LAST, V_LAST, 1'b0, 1'b0, BLACK};

  pipe_delay #(.WIDTH(DW), .DEPTH(MEM_LATENCY)) coordPipe (
    .clk     (clk),
    .reset   (reset),
    .dataIn  (pipeIn),
    .dataOut (pipeOut)
  );

  assign {dScan, dHc, dVc, dAct, dFb, dPix} = pipeOut;

  // A cleared pipeline stage carries dScan=0, so x/y show the idle corner
  // rather than a false (0,0) while the line refills after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= H_LAST;
      y           <= V_LAST;
      pixel       <= BLACK;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= dScan ? dHc : H_LAST;
      y           <= dScan ? dVc : V_LAST;
      active      <= dAct;
      frame_start <= dScan && (dHc == '0) && (dVc == '0);
      pixel       <= !dAct ? BLACK : (dFb ? mem_data : dPix);
    end
  end

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Raster scanner that produces the pixel stream consumed by colour tracking blocks: one pixel per clk, with x/y coordinates that include blanking.
- Active pixels come either from a frame-buffer read port with fixed latency or from built-in test patterns.
- Test patterns include a red square at a programmable location, for closed-loop checking of centre-of-mass logic.
- Sits between the frame-buffer memory controller and the tracking/display pipeline.

Parameters:
- H_ACTIVE, 1024, active pixels per line
- H_TOTAL, 1344, pixels per line including blanking (≤2047)
- V_ACTIVE, 768, active lines per frame
- V_TOTAL, 806, lines per frame including blanking (≤1023)
- MEM_LATENCY, 2, cycles from mem_rd to valid mem_data (≥1)
- BOX, 16, side length of test-pattern square
- ADDR_W, 20, frame-buffer address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; sampled only at frame boundaries
- pattern_sel  in  2  0 frame buffer, 1 colour bars, 2 red box, 3 black
- box_x  in  11  left edge of box
- box_y  in  10  top edge of box
- mem_rd  out  1  frame-buffer read strobe
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_data  in  18  read data {R[5:0],G[5:0],B[5:0]}, valid MEM_LATENCY cycles after mem_rd
- pixel  out  18  output pixel
- x  out  11  output column, 0..H_TOTAL-1
- y  out  10  output row, 0..V_TOTAL-1
- active  out  1  x<H_ACTIVE && y<V_ACTIVE
- frame_start  out  1  one-cycle pulse coincident with x==0,y==0

Behaviour:
- Reset (asynchronous assertion) values:
  - x=H_TOTAL-1, y=V_TOTAL-1
  - pixel=0, active=0, frame_start=0
  - mem_rd=0, mem_addr=0
  - FSM=IDLE
- FSM states:
  - IDLE: scan counters hc=H_TOTAL-1, vc=V_TOTAL-1; no reads. IDLE -> SCAN on enable=1, with hc=vc=0 on the next cycle.
  - SCAN: hc increments each cycle. At hc=H_TOTAL-1, hc wraps to 0 and vc increments.
  - Frame end (hc=H_TOTAL-1, vc=V_TOTAL-1): if enable=1, wrap to (0,0); else -> IDLE.
  - Enable deassertion mid-frame is ignored until frame end. Frames are never truncated.
- Frame-start latching:
  - Latch pattern_sel, box_x and box_y on the scan cycle where hc=0,vc=0.
  - Changes mid-frame take effect on the next frame.
- Frame-buffer reads:
  - mem_rd = SCAN && latched pattern==0 && hc<H_ACTIVE && vc<V_ACTIVE (registered from next-state counters, so it is aligned with hc/vc).
  - mem_addr is an incrementing counter, not a multiplier:
    - set to 0 at frame start;
    - increments after each mem_rd=1 cycle;
    - the address for (hc,vc) equals vc*H_ACTIVE+hc.
- Pipeline:
  - hc, vc, active flag and the pattern pixel pass through a MEM_LATENCY-deep delay line.
  - Outputs are registered. Output latency from scan cycle to x/y/pixel is exactly MEM_LATENCY+1 for every pattern mode.
- Pixel selection at output:
  - If not active, pixel = 0.
  - Pattern 0: pixel = mem_data.
  - Pattern 1: 8 bars of width H_ACTIVE/8, left to right: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 6'h3F or 0.
  - Pattern 2: pixel = 18'h3F000 if box_x≤x<box_x+BOX and box_y≤y<box_y+BOX, else 0. Use 12/11-bit compares so that box+BOX does not wrap; a box that extends beyond the active area is clipped.
  - Pattern 3: pixel = 0.
- Outputs in IDLE:
  - x/y hold at H_TOTAL-1/V_TOTAL-1 once the pipeline drains, and active=0.
  - (0,0) never appears except at a real frame start, so downstream frame-boundary detection is not falsely retriggered.
- frame_start = 1 exactly when output x==0 && y==0 in SCAN.
- Reset mid-frame: the scan is aborted, all state returns to reset values, and in-flight read data is discarded.

Decomposition:
- Shared package video_pkg:
  - pixel width (18) and channel width (6);
  - pattern_sel encodings (PAT_FB, PAT_BARS, PAT_BOX, PAT_BLACK);
  - colour constants (RED, WHITE, ...) and the bar colour table.
- One sub-module, pipe_delay (parameters WIDTH, DEPTH, async active-low reset to 0):
  - carries {hc, vc, active, pattern pixel};
  - the IDLE hold value is applied at its input.

Test Plan (bench with H_ACTIVE=8, H_TOTAL=12, V_ACTIVE=4, V_TOTAL=6, MEM_LATENCY=2, BOX=2 unless noted):
- Reset, enable=0 for 20 cycles -> x=11, y=5, active=0, frame_start=0, mem_rd=0 throughout.
- enable=1, pattern 0, memory model returns addr as data -> mem_addr 0..31 in raster order with mem_rd high exactly 32 cycles per 72-cycle frame; pixel at (x,y) = y*8+x for active pixels and 0 in blanking; first output (0,0) appears 3 cycles after the first scan cycle.
- pattern 2, box_x=3, box_y=1 -> exactly 4 pixels equal 18'h3F000, at (3,1), (4,1), (3,2), (4,2); all others 0; box_x=7 -> clipped to 2 pixels.
- pattern 1 with H_ACTIVE=16 -> (0,0)=18'h3FFFF, (2,0)=18'h3FFC0, (10,0)=18'h3F000, (15,0)=0.
- Drop enable at output (5,2) -> frame completes through (11,5); no further (0,0); x/y hold at 11/5.
- Change pattern_sel 0->2 mid-frame -> current frame stays frame buffer with mem_rd pattern unchanged; next frame is box with no mem_rd.
- Assert reset at (4,3) mid-frame -> outputs immediately go to reset values; re-enable -> the next frame starts cleanly at (0,0) with mem_addr 0.
